// File: rtl/hex_display_driver.sv
// ---------------------------------------------------------------------------
// hex_display_driver
//
// Purpose:
//   This is the display stage that follows the RPN calculator core.
//   A one-cycle load strobe captures an 8-bit result. The value can be
//   read as unsigned or as two's complement, and an error flag can be
//   captured with it. The magnitude becomes three BCD digits through a
//   double-dabble engine that handles one bit per clock. The six
//   active-low seven-segment outputs then show one of two things:
//     - the number, with an optional minus sign and leading-zero
//       blanking, or
//     - the "Error" banner.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   load         in   one-cycle capture strobe (honoured only while ready)
//   value[7:0]   in   number to display
//   signed_mode  in   1: value is two's complement, 0: unsigned
//   err_in       in   1: show "Error" instead of the value
//   ready        out  idle and able to accept a load
//   done         out  one-cycle pulse right after the HEX outputs update
//   HEX0..HEX5   out  active-low segments {g,f,e,d,c,b,a}, HEX0 rightmost
// ---------------------------------------------------------------------------
module hex_display_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       signed_mode,
  input  logic       err_in,
  output logic       ready,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_R    = 7'b0101111;
  localparam logic [6:0] SEG_O    = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [7:0]      mag_q, mag_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [5:0][6:0] hex_q, hex_d;

  // Active-low seven-segment pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Adds 3 to every BCD nibble that is >= 5, then shifts the combined
  // {bcd, mag} register left by one bit. Doing the adjustment first keeps
  // every nibble at 9 or below after the shift.
  function automatic logic [19:0] dabble_step(input logic [11:0] bcd,
                                               input logic [7:0]  mag);
    logic [11:0] adj;
    logic [19:0] sh;
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                              : bcd[i*4 +: 4];
    end
    sh = {adj, mag};
    return {sh[18:0], 1'b0};
  endfunction

  // Builds the full six-digit frame {HEX5 .. HEX0}.
  function automatic logic [41:0] format_frame(input logic        err,
                                               input logic        neg,
                                               input logic [11:0] bcd);
    logic [6:0] h5, h4, h3, h2, h1, h0;
    if (err) begin
      h5 = SEG_OFF;
      h4 = SEG_E;
      h3 = SEG_R;
      h2 = SEG_R;
      h1 = SEG_O;
      h0 = SEG_R;
    end else begin
      h5 = SEG_OFF;
      h4 = SEG_OFF;
      h3 = neg ? SEG_DASH : SEG_OFF;
      h2 = (bcd[11:8] == 4'd0) ? SEG_OFF : seg7(bcd[11:8]);
      // Tens blank only when hundreds is blank too (e.g. 105 keeps its 0).
      h1 = (bcd[11:4] == 8'd0) ? SEG_OFF : seg7(bcd[7:4]);
      h0 = seg7(bcd[3:0]);
    end
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    err_d   = err_q;
    hex_d   = hex_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          neg_d   = signed_mode & value[7];
          // Negating -128 wraps to 8'h80, which is the required magnitude 128.
          mag_d   = (signed_mode & value[7]) ? (~value) + 8'd1 : value;
          err_d   = err_in;
          bcd_d   = 12'd0;
          cnt_d   = 4'd0;
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        {bcd_d, mag_d} = dabble_step(bcd_q, mag_q);
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        hex_d   = format_frame(err_q, neg_q, bcd_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      bcd_q   <= 12'd0;
      mag_q   <= 8'd0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= {6{SEG_OFF}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[5];

endmodule
